// File: rtl/loop_counter_bank_pkg.sv
// Shared constants, control struct and slice helper for the loop-index counter bank.
package loop_cnt_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_CHANNELS = 3;

  // Cells take the low WIDTH bits, so any WIDTH up to 64 resets to all ones.
  localparam logic [63:0] LIMIT_RST_ALL = '1;

  typedef struct packed {
    logic load;
    logic limit_load;
    logic inc_eff;
  } cell_ctrl_t;

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/loop_counter_bank_if.sv
// Bus bundle between the controller (master) and the counter bank (slave).
interface loop_counter_bank_if #(
  parameter int WIDTH    = loop_cnt_pkg::DEF_WIDTH,
  parameter int CHANNELS = loop_cnt_pkg::DEF_CHANNELS
);
  logic [CHANNELS-1:0]       load_enable;
  logic [CHANNELS-1:0]       limit_load;
  logic [CHANNELS-1:0]       inc;
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [CHANNELS*WIDTH-1:0] data_out;
  logic [CHANNELS-1:0]       wrap;
  logic [CHANNELS-1:0]       at_limit;

  modport master (
    output load_enable, limit_load, inc, data_in,
    input  data_out, wrap, at_limit
  );

  modport slave (
    input  load_enable, limit_load, inc, data_in,
    output data_out, wrap, at_limit
  );
endinterface

// File: rtl/loop_counter_bank_cell.sv
// One counter channel: count and limit registers, wrap compare and registered wrap pulse.
module loop_counter_cell
  import loop_cnt_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  cell_ctrl_t       i_ctrl,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_count,
  output logic             o_wrap,
  output logic             o_wrap_evt,
  output logic             o_at_limit
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_limit;
  logic             r_wrap;
  logic             w_at_limit;
  logic             w_wrap_evt;

  // Compare uses the old limit even when a new one is being loaded this cycle.
  assign w_at_limit = (r_count >= r_limit);
  assign w_wrap_evt = i_ctrl.inc_eff & ~i_ctrl.load & w_at_limit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_limit <= LIMIT_RST_ALL[WIDTH-1:0];
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= w_wrap_evt;
      if (i_ctrl.load)
        r_count <= i_data;
      else if (w_wrap_evt)
        r_count <= '0;
      else if (i_ctrl.inc_eff)
        r_count <= r_count + WIDTH'(1);
      if (i_ctrl.limit_load)
        r_limit <= i_data;
    end
  end

  assign o_count    = r_count;
  assign o_wrap     = r_wrap;
  assign o_wrap_evt = w_wrap_evt;
  assign o_at_limit = w_at_limit;

endmodule

// File: rtl/loop_counter_bank.sv
// Bank of CHANNELS loop-index counters; define LOOP_CNT_CHAIN_EN to chain channel
// wraps into the next channel's increment (channel 0 innermost).
module loop_counter_bank
  import loop_cnt_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
) (
  input logic                clk,
  input logic                reset,
  loop_counter_bank_if.slave bus
);

  logic [CHANNELS-1:0] w_wrap_evt;
  logic [CHANNELS-1:0] w_inc_eff;
  // The outermost wrap event has no consumer (and none at all when unchained).
  logic                w_unused_wrap_evt;

  assign w_unused_wrap_evt = ^w_wrap_evt;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      localparam int LO = slice_lo(gi, WIDTH);
      cell_ctrl_t w_ctrl;

      if (gi == 0) begin : g_first
        assign w_inc_eff[gi] = bus.inc[gi];
      end else begin : g_rest
`ifdef LOOP_CNT_CHAIN_EN
        assign w_inc_eff[gi] = bus.inc[gi] | w_wrap_evt[gi-1];
`else
        assign w_inc_eff[gi] = bus.inc[gi];
`endif
      end

      assign w_ctrl.load       = bus.load_enable[gi];
      assign w_ctrl.limit_load = bus.limit_load[gi];
      assign w_ctrl.inc_eff    = w_inc_eff[gi];

      loop_counter_cell #(.WIDTH(WIDTH)) u_cell (
        .clk        (clk),
        .reset      (reset),
        .i_ctrl     (w_ctrl),
        .i_data     (bus.data_in[LO +: WIDTH]),
        .o_count    (bus.data_out[LO +: WIDTH]),
        .o_wrap     (bus.wrap[gi]),
        .o_wrap_evt (w_wrap_evt[gi]),
        .o_at_limit (bus.at_limit[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_loop_counter_bank.sv
// Directed self-checking bench for loop_counter_bank (WIDTH=16, CHANNELS=3).
module tb_loop_counter_bank;

  localparam int W = 16;
  localparam int C = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  loop_counter_bank_if #(.WIDTH(W), .CHANNELS(C)) bus ();

  loop_counter_bank #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] cnt(input int ch);
    return bus.data_out[ch*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t rst=%0b ld=%b ll=%b inc=%b din=%h dout=%h wrap=%b atl=%b",
             $time, reset, bus.load_enable, bus.limit_load, bus.inc, bus.data_in,
             bus.data_out, bus.wrap, bus.at_limit);
  endtask

  task automatic idle();
    bus.load_enable = '0;
    bus.limit_load  = '0;
    bus.inc         = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    bus.data_in = '0;
    tick();
    tick();
    reset = 1'b0;
    n_checks++;
    if (bus.data_out !== 48'h0) begin
      n_fail++; $display("FAIL reset_data_out got=%h exp=0", bus.data_out);
    end
    n_checks++;
    if (bus.wrap !== 3'b000) begin
      n_fail++; $display("FAIL reset_wrap got=%b exp=000", bus.wrap);
    end
    n_checks++;
    if (bus.at_limit !== 3'b000) begin
      n_fail++; $display("FAIL reset_at_limit got=%b exp=000", bus.at_limit);
    end
  endtask

  task automatic test_inc3();
    bus.inc = 3'b001;
    for (int k = 0; k < 3; k++) tick();
    bus.inc = '0;
    n_checks++;
    if (bus.data_out !== {16'h0, 16'h0, 16'h3}) begin
      n_fail++; $display("FAIL inc3_data_out got=%h exp=000000000003", bus.data_out);
    end
    n_checks++;
    if (bus.wrap !== 3'b000) begin
      n_fail++; $display("FAIL inc3_wrap got=%b exp=000", bus.wrap);
    end
  endtask

  task automatic test_limit4();
    logic [W-1:0] exp_cnt [6] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd1};
    bus.data_in     = {16'h0, 16'h0, 16'h0};
    bus.load_enable = 3'b001;
    tick();
    bus.load_enable = '0;
    bus.data_in     = {16'h0, 16'h0, 16'h4};
    bus.limit_load  = 3'b001;
    tick();
    bus.limit_load  = '0;
    bus.inc         = 3'b001;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++;
      if (cnt(0) !== exp_cnt[k]) begin
        n_fail++; $display("FAIL limit4_count step=%0d got=%0d exp=%0d", k, cnt(0), exp_cnt[k]);
      end
      n_checks++;
      if (bus.wrap[0] !== (exp_cnt[k] == 16'd0)) begin
        n_fail++; $display("FAIL limit4_wrap step=%0d got=%b exp=%b", k, bus.wrap[0], exp_cnt[k] == 16'd0);
      end
      n_checks++;
      if (bus.at_limit[0] !== (exp_cnt[k] == 16'd4)) begin
        n_fail++; $display("FAIL limit4_at_limit step=%0d got=%b exp=%b", k, bus.at_limit[0], exp_cnt[k] == 16'd4);
      end
    end
    bus.inc = '0;
  endtask

  task automatic test_load_inc();
    bus.data_in     = {16'h0, 16'h7, 16'h0};
    bus.load_enable = 3'b010;
    bus.inc         = 3'b010;
    tick();
    n_checks++;
    if (cnt(1) !== 16'd7 || bus.wrap[1] !== 1'b0) begin
      n_fail++; $display("FAIL load_inc_load got=%0d/%b exp=7/0", cnt(1), bus.wrap[1]);
    end
    bus.load_enable = '0;
    tick();
    bus.inc = '0;
    n_checks++;
    if (cnt(1) !== 16'd8) begin
      n_fail++; $display("FAIL load_inc_next got=%0d exp=8", cnt(1));
    end
  endtask

  task automatic test_free_wrap();
    bus.data_in     = {16'hFFFF, 16'h0, 16'h0};
    bus.load_enable = 3'b100;
    tick();
    bus.load_enable = '0;
    n_checks++;
    if (cnt(2) !== 16'hFFFF || bus.at_limit[2] !== 1'b1 || bus.wrap[2] !== 1'b0) begin
      n_fail++; $display("FAIL free_load got=%h/%b/%b exp=ffff/1/0", cnt(2), bus.at_limit[2], bus.wrap[2]);
    end
    bus.inc = 3'b100;
    tick();
    bus.inc = '0;
    n_checks++;
    if (cnt(2) !== 16'h0 || bus.wrap[2] !== 1'b1) begin
      n_fail++; $display("FAIL free_wrap got=%h/%b exp=0000/1", cnt(2), bus.wrap[2]);
    end
    tick();
    n_checks++;
    if (bus.wrap[2] !== 1'b0) begin
      n_fail++; $display("FAIL free_wrap_pulse got=%b exp=0", bus.wrap[2]);
    end
    bus.data_in    = '0;
    bus.limit_load = 3'b100;
    tick();
    bus.limit_load = '0;
    bus.inc        = 3'b100;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (cnt(2) !== 16'h0 || bus.wrap[2] !== 1'b1 || bus.at_limit[2] !== 1'b1) begin
        n_fail++; $display("FAIL limit0 step=%0d got=%h/%b/%b exp=0000/1/1", k, cnt(2), bus.wrap[2], bus.at_limit[2]);
      end
    end
    bus.inc = '0;
  endtask

  task automatic test_over_limit();
    bus.data_in     = {16'h0, 16'h0, 16'h9};
    bus.load_enable = 3'b001;
    tick();
    bus.load_enable = '0;
    n_checks++;
    if (cnt(0) !== 16'd9 || bus.at_limit[0] !== 1'b1 || bus.wrap[0] !== 1'b0) begin
      n_fail++; $display("FAIL over_load got=%0d/%b/%b exp=9/1/0", cnt(0), bus.at_limit[0], bus.wrap[0]);
    end
    bus.inc = 3'b001;
    tick();
    bus.inc = '0;
    n_checks++;
    if (cnt(0) !== 16'd0 || bus.wrap[0] !== 1'b1) begin
      n_fail++; $display("FAIL over_wrap got=%0d/%b exp=0/1", cnt(0), bus.wrap[0]);
    end
  endtask

  task automatic test_both_load();
    bus.data_in     = {16'h0, 16'h5, 16'h0};
    bus.load_enable = 3'b010;
    bus.limit_load  = 3'b010;
    tick();
    idle();
    n_checks++;
    if (cnt(1) !== 16'd5 || bus.at_limit[1] !== 1'b1) begin
      n_fail++; $display("FAIL both_load got=%0d/%b exp=5/1", cnt(1), bus.at_limit[1]);
    end
    bus.inc = 3'b010;
    tick();
    n_checks++;
    if (cnt(1) !== 16'd0 || bus.wrap[1] !== 1'b1) begin
      n_fail++; $display("FAIL both_wrap got=%0d/%b exp=0/1", cnt(1), bus.wrap[1]);
    end
    tick();
    bus.inc = '0;
    n_checks++;
    if (cnt(1) !== 16'd1 || bus.wrap[1] !== 1'b0) begin
      n_fail++; $display("FAIL both_after got=%0d/%b exp=1/0", cnt(1), bus.wrap[1]);
    end
  endtask

  task automatic test_reset_mid();
    bus.inc = 3'b111;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.inc = '0;
    n_checks++;
    if (bus.data_out !== 48'h0 || bus.wrap !== 3'b000) begin
      n_fail++; $display("FAIL reset_mid got=%h/%b exp=0/000", bus.data_out, bus.wrap);
    end
    bus.data_in     = {16'hFFFF, 16'hFFFF, 16'hFFFF};
    bus.load_enable = 3'b111;
    tick();
    n_checks++;
    if (bus.at_limit !== 3'b111) begin
      n_fail++; $display("FAIL reset_mid_limit_hi got=%b exp=111", bus.at_limit);
    end
    bus.data_in = {16'hFFFE, 16'hFFFE, 16'hFFFE};
    tick();
    bus.load_enable = '0;
    n_checks++;
    if (bus.at_limit !== 3'b000) begin
      n_fail++; $display("FAIL reset_mid_limit_lo got=%b exp=000", bus.at_limit);
    end
  endtask

`ifdef LOOP_CNT_CHAIN_EN
  task automatic test_chain();
    int m0, m1, m2, lim [3];
    logic e0, e1, e2;
    lim = '{1, 2, 1};
    m0 = 0; m1 = 0; m2 = 0;
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    bus.data_in    = {16'd1, 16'd2, 16'd1};
    bus.limit_load = 3'b111;
    tick();
    bus.limit_load = '0;
    bus.inc        = 3'b001;
    for (int k = 1; k <= 12; k++) begin
      e0 = (m0 >= lim[0]);
      e1 = e0 && (m1 >= lim[1]);
      e2 = e1 && (m2 >= lim[2]);
      m0 = e0 ? 0 : m0 + 1;
      if (e0) m1 = e1 ? 0 : m1 + 1;
      if (e1) m2 = e2 ? 0 : m2 + 1;
      tick();
      n_checks++;
      if (bus.data_out !== {m2[W-1:0], m1[W-1:0], m0[W-1:0]} || bus.wrap !== {e2, e1, e0}) begin
        n_fail++; $display("FAIL chain cycle=%0d got=%h/%b exp=%0d,%0d,%0d/%b", k, bus.data_out, bus.wrap, m2, m1, m0, {e2, e1, e0});
      end
    end
    bus.inc = '0;
    n_checks++;
    if (bus.wrap !== 3'b111) begin
      n_fail++; $display("FAIL chain_final_wrap got=%b exp=111", bus.wrap);
    end
  endtask
`endif

  initial begin
    idle();
    bus.data_in = '0;
    test_reset();
    test_inc3();
    test_limit4();
    test_load_inc();
    test_free_wrap();
    test_over_limit();
    test_both_load();
    test_reset_mid();
`ifdef LOOP_CNT_CHAIN_EN
    test_chain();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
